uart_hs_host: RTL and testbench

UART_HS_HOST -- requirements
Module: uart_hs_host

---
 rtl/uart_hs_host.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_hs_host.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_hs_host.sv
// uart_hs_host: host-side buffering between a CPU-style valid/ready port and
// a req/ack UART transmitter and receiver. TX path is a FIFO_DEPTH-entry
// FIFO drained by a four-phase send_req/send_ack handshake; RX path captures
// characters on recv_req/recv_ack and presents them on rd_valid/rd_ready.
// Ports: clk, reset_n (sync, active low); wr_valid/wr_data/wr_ready (TX in);
// rd_valid/rd_data/rd_ready (RX out); send_req/send_ack/tx_data (transmitter);
// recv_req/recv_ack/rx_data (receiver); tx_level (TX occupancy).
// Build option: define UART_HS_HOST_RX_FIFO_EN for a FIFO_DEPTH-entry RX FIFO;
// otherwise the RX buffer is a single holding register.
module uart_hs_host #(
  parameter int DATA_SIZE  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            wr_valid,
  input  logic [DATA_SIZE-1:0]            wr_data,
  output logic                            wr_ready,
  output logic                            rd_valid,
  output logic [DATA_SIZE-1:0]            rd_data,
  input  logic                            rd_ready,
  output logic                            send_req,
  input  logic                            send_ack,
  output logic [DATA_SIZE-1:0]            tx_data,
  input  logic                            recv_req,
  output logic                            recv_ack,
  input  logic [DATA_SIZE-1:0]            rx_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] tx_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_e;
  typedef enum logic {R_IDLE, R_ACK} rx_state_e;

  // ---------------- TX path ----------------
  logic [DATA_SIZE-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_SIZE-1:0] tx_mem_d [FIFO_DEPTH];
  logic [PW-1:0]        tx_wptr_q, tx_wptr_d;
  logic [PW-1:0]        tx_rptr_q, tx_rptr_d;
  logic [LW-1:0]        tx_cnt_q, tx_cnt_d;
  tx_state_e            tx_state_q, tx_state_d;
  logic                 send_req_q, send_req_d;
  logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
  logic                 tx_push, tx_pop;

  assign wr_ready = reset_n && (tx_cnt_q != FULL_LVL);
  assign tx_push  = wr_valid && wr_ready;
  // The head leaves the FIFO only once the transmitter has acknowledged it.
  assign tx_pop   = (tx_state_q == T_REQ) && send_ack;
  assign send_req = send_req_q;
  assign tx_data  = tx_data_q;
  assign tx_level = tx_cnt_q;

  always_comb begin
    tx_mem_d   = tx_mem_q;
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_cnt_d   = tx_cnt_q;
    tx_state_d = tx_state_q;
    send_req_d = send_req_q;
    tx_data_d  = tx_data_q;
    if (tx_push) begin
      tx_mem_d[tx_wptr_q] = wr_data;
      tx_wptr_d = tx_wptr_q + PW'(1);
    end
    if (tx_pop) begin
      tx_rptr_d = tx_rptr_q + PW'(1);
    end
    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + LW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - LW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    unique case (tx_state_q)
      T_IDLE: begin
        // Wait for a stale ack to drop before opening a new handshake.
        if ((tx_cnt_q != '0) && !send_ack) begin
          tx_data_d  = tx_mem_q[tx_rptr_q];
          send_req_d = 1'b1;
          tx_state_d = T_REQ;
        end
      end
      T_REQ: begin
        if (send_ack) begin
          send_req_d = 1'b0;
          tx_state_d = T_REL;
        end
      end
      T_REL: begin
        if (!send_ack) begin
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      tx_state_q <= T_IDLE;
      send_req_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_state_q <= tx_state_d;
      send_req_q <= send_req_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // ---------------- RX path ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic                 recv_ack_q, recv_ack_d;
  logic                 rx_space, rx_avail;
  logic                 rx_cap, rx_pop;
  logic [DATA_SIZE-1:0] rx_head;

  // Capture only from idle, so one recv_req pulse yields one character.
  assign rx_cap   = (rx_state_q == R_IDLE) && recv_req && rx_space;
  assign rx_pop   = rx_avail && rd_ready;
  assign rd_valid = rx_avail;
  assign rd_data  = rx_avail ? rx_head : '0;
  assign recv_ack = recv_ack_q;

  always_comb begin
    rx_state_d = rx_state_q;
    recv_ack_d = recv_ack_q;
    unique case (rx_state_q)
      R_IDLE: begin
        if (rx_cap) begin
          recv_ack_d = 1'b1;
          rx_state_d = R_ACK;
        end
      end
      R_ACK: begin
        if (!recv_req) begin
          recv_ack_d = 1'b0;
          rx_state_d = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state_q <= R_IDLE;
      recv_ack_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      recv_ack_q <= recv_ack_d;
    end
  end

`ifdef UART_HS_HOST_RX_FIFO_EN
  logic [DATA_SIZE-1:0] rx_mem_q [FIFO_DEPTH];
  logic [DATA_SIZE-1:0] rx_mem_d [FIFO_DEPTH];
  logic [PW-1:0]        rx_wptr_q, rx_wptr_d;
  logic [PW-1:0]        rx_rptr_q, rx_rptr_d;
  logic [LW-1:0]        rx_cnt_q, rx_cnt_d;

  assign rx_space = (rx_cnt_q != FULL_LVL);
  assign rx_avail = (rx_cnt_q != '0);
  assign rx_head  = rx_mem_q[rx_rptr_q];

  always_comb begin
    rx_mem_d  = rx_mem_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    if (rx_cap) begin
      rx_mem_d[rx_wptr_q] = rx_data;
      rx_wptr_d = rx_wptr_q + PW'(1);
    end
    if (rx_pop) begin
      rx_rptr_d = rx_rptr_q + PW'(1);
    end
    unique case ({rx_cap, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + LW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - LW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    rx_mem_q <= rx_mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end
`else
  logic [DATA_SIZE-1:0] rx_hold_q, rx_hold_d;
  logic                 rx_full_q, rx_full_d;

  // A held character blocks capture even while it is being read.
  assign rx_space = !rx_full_q;
  assign rx_avail = rx_full_q;
  assign rx_head  = rx_hold_q;

  always_comb begin
    rx_hold_d = rx_hold_q;
    rx_full_d = rx_full_q;
    if (rx_cap) begin
      rx_hold_d = rx_data;
      rx_full_d = 1'b1;
    end else if (rx_pop) begin
      rx_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_hold_q <= '0;
      rx_full_q <= 1'b0;
    end else begin
      rx_hold_q <= rx_hold_d;
      rx_full_q <= rx_full_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_hs_host.sv
// tb_uart_hs_host: directed bench for uart_hs_host with a queue-based
// reference model compared every cycle plus hand-computed literal checks.
module tb_uart_hs_host;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);
`ifdef UART_HS_HOST_RX_FIFO_EN
  localparam int RXCAP = DEPTH;
`else
  localparam int RXCAP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic          send_req;
  logic          send_ack;
  logic [DW-1:0] tx_data;
  logic          recv_req;
  logic          recv_ack;
  logic [DW-1:0] rx_data;
  logic [LW-1:0] tx_level;

  uart_hs_host #(.DATA_SIZE(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .send_req (send_req),
    .send_ack (send_ack),
    .tx_data  (tx_data),
    .recv_req (recv_req),
    .recv_ack (recv_ack),
    .rx_data  (rx_data),
    .tx_level (tx_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference model state: buffers as queues, handshake phases as flags.
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] sent[$];
  logic [DW-1:0] rx_got[$];
  bit            m_req;
  bit            m_rel;
  bit            m_ack;
  logic [DW-1:0] m_txd;
  int            ack_delay  = 3;
  int            req_cycles = 0;

  always @(posedge clk) begin
    bit            push;
    bit            rpop;
    bit            cap;
    logic [LW-1:0] e_lvl;
    logic [DW-1:0] e_rd;
    bit            e_wr;
    if (send_req && send_ack) sent.push_back(tx_data);
    if (rd_valid && rd_ready) rx_got.push_back(rd_data);
    if (!reset_n) begin
      tx_q.delete();
      rx_q.delete();
      m_req = 1'b0;
      m_rel = 1'b0;
      m_ack = 1'b0;
      m_txd = '0;
    end else begin
      push = wr_valid && (tx_q.size() < DEPTH);
      if (m_req && send_ack) begin
        void'(tx_q.pop_front());
        m_req = 1'b0;
        m_rel = 1'b1;
      end else if (m_rel) begin
        if (!send_ack) m_rel = 1'b0;
      end else if (!m_req && tx_q.size() != 0 && !send_ack) begin
        m_req = 1'b1;
        m_txd = tx_q[0];
      end
      if (push) tx_q.push_back(wr_data);
      rpop = (rx_q.size() != 0) && rd_ready;
      cap  = !m_ack && recv_req && (rx_q.size() < RXCAP);
      if (m_ack && !recv_req) m_ack = 1'b0;
      if (rpop) void'(rx_q.pop_front());
      if (cap) begin
        rx_q.push_back(rx_data);
        m_ack = 1'b1;
      end
    end
    #1;
    e_lvl = LW'(tx_q.size());
    e_rd  = (rx_q.size() != 0) ? rx_q[0] : '0;
    e_wr  = reset_n && (tx_q.size() < DEPTH);
    n_tests++;
    if (send_req !== m_req || tx_data !== m_txd || tx_level !== e_lvl ||
        wr_ready !== e_wr || recv_ack !== m_ack ||
        rd_valid !== (rx_q.size() != 0) || rd_data !== e_rd) begin
      n_fail++;
      $display("FAIL cycle t=%0t got req=%b txd=%h lvl=%0d wrr=%b ack=%b rdv=%b rdd=%h want req=%b txd=%h lvl=%0d wrr=%b ack=%b rdv=%b rdd=%h",
               $time, send_req, tx_data, tx_level, wr_ready, recv_ack,
               rd_valid, rd_data, m_req, m_txd, e_lvl, e_wr, m_ack,
               rx_q.size() != 0, e_rd);
    end
  end

  // Transmitter model: ack after ack_delay cycles of send_req, release
  // once send_req falls.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      send_ack   = 1'b0;
      req_cycles = 0;
    end else if (send_req) begin
      if (!send_ack) begin
        req_cycles++;
        if (req_cycles >= ack_delay) send_ack = 1'b1;
      end
    end else begin
      req_cycles = 0;
      send_ack   = 1'b0;
    end
  end

  task automatic wait_tx_idle();
    int n;
    n = 0;
    while ((tx_level != 0 || send_req || send_ack) && n < 200) begin
      step();
      n++;
    end
    chk("tx_idle", (tx_level == 0) && !send_req && !send_ack, 1);
  endtask

  task automatic rx_offer(input logic [DW-1:0] d, output bit acked);
    rx_data  = d;
    recv_req = 1'b1;
    acked    = 1'b0;
    for (int i = 0; i < 6 && !acked; i++) begin
      step();
      if (recv_ack) acked = 1'b1;
    end
    if (acked) begin
      recv_req = 1'b0;
      for (int i = 0; i < 6 && recv_ack; i++) step();
    end
  endtask

  initial begin
    bit ok;
    int n;
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    send_ack = 1'b0;
    recv_req = 1'b0;
    rx_data  = '0;
    repeat (3) step();
    chk("rst_send_req", send_req, 0);
    chk("rst_recv_ack", recv_ack, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rd_data", rd_data, 0);
    reset_n = 1'b1;
    step();
    chk("wr_ready_up", wr_ready, 1);

    // Single character with 3-cycle ack.
    sent.delete();
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("a5_level", tx_level, 1);
    chk("a5_req_early", send_req, 0);
    step();
    chk("a5_req", send_req, 1);
    chk("a5_tx_data", tx_data, 8'hA5);
    n = 0;
    while (send_req && n < 20) begin
      step();
      n++;
    end
    chk("a5_req_cycles", n, 3);
    chk("a5_popped", tx_level, 0);
    chk("a5_rel_ack", send_ack, 1);
    step();
    chk("a5_rel_no_req", send_req, 0);
    wait_tx_idle();
    chk("a5_sent", sent.size() == 1 ? 32'(sent[0]) : 32'hFFF, 32'hA5);

    // Fill to depth, fifth push ignored, in-order drain.
    sent.delete();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i + 1);
      step();
    end
    chk("fill_level", tx_level, 4);
    chk("fill_wr_ready", wr_ready, 0);
    wr_data = 8'h05;
    step();
    wr_valid = 1'b0;
    chk("fifth_level", tx_level, 3);
    wait_tx_idle();
    chk("fill_count", sent.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_order", sent.size() > i ? 32'(sent[i]) : 32'hFFF, i + 1);
    end

    // Push and pop on the same edge at level 2.
    ack_delay = 1000;
    wr_valid  = 1'b1;
    wr_data   = 8'h21;
    step();
    wr_data = 8'h22;
    step();
    wr_valid = 1'b0;
    chk("pp_req", send_req, 1);
    chk("pp_level", tx_level, 2);
    ack_delay = 0;
    wr_valid  = 1'b1;
    wr_data   = 8'h23;
    step();
    wr_valid = 1'b0;
    chk("pp_level_same", tx_level, 2);
    ack_delay = 3;
    wait_tx_idle();

    // Single RX character with host ready.
    rx_got.delete();
    rd_ready = 1'b1;
    rx_data  = 8'h3C;
    recv_req = 1'b1;
    step();
    chk("rx_ack", recv_ack, 1);
    chk("rx_valid", rd_valid, 1);
    chk("rx_data", rd_data, 8'h3C);
    recv_req = 1'b0;
    step();
    chk("rx_ack_drop", recv_ack, 0);
    chk("rx_drained", rd_valid, 0);
    chk("rx_got", rx_got.size() == 1 ? 32'(rx_got[0]) : 32'hFFF, 32'h3C);

    // RX back-pressure then drain.
    rd_ready = 1'b0;
    rx_got.delete();
    for (int k = 0; k <= RXCAP; k++) begin
      rx_offer(8'(16 + k), ok);
      chk("rx_accept", ok, k < RXCAP);
    end
    chk("rx_stall_ack", recv_ack, 0);
    chk("rx_head", rd_data, 8'h10);
    rd_ready = 1'b1;
    n = 0;
    while (!recv_ack && n < 20) begin
      step();
      n++;
    end
    chk("rx_late_ack", recv_ack, 1);
    recv_req = 1'b0;
    n = 0;
    while ((recv_ack || rd_valid) && n < 40) begin
      step();
      n++;
    end
    chk("rx_empty", rd_valid, 0);
    chk("rx_count", rx_got.size(), RXCAP + 1);
    for (int k = 0; k <= RXCAP; k++) begin
      chk("rx_order", rx_got.size() > k ? 32'(rx_got[k]) : 32'hFFF, 16 + k);
    end
    rd_ready = 1'b0;

    // Reset in the middle of both handshakes.
    ack_delay = 1000;
    wr_valid  = 1'b1;
    wr_data   = 8'h77;
    rx_data   = 8'h55;
    recv_req  = 1'b1;
    step();
    wr_valid = 1'b0;
    step();
    chk("mid_req", send_req, 1);
    chk("mid_ack", recv_ack, 1);
    reset_n = 1'b0;
    step();
    chk("mrst_send_req", send_req, 0);
    chk("mrst_recv_ack", recv_ack, 0);
    chk("mrst_tx_level", tx_level, 0);
    chk("mrst_rd_valid", rd_valid, 0);
    recv_req = 1'b0;
    step();
    reset_n   = 1'b1;
    ack_delay = 3;
    step();
    chk("post_rst_ready", wr_ready, 1);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
